// File: rtl/pdp11_reset_pkg.sv
// pdp11_reset_pkg: shared state encoding and default delays for the reset sequencer
package pdp11_reset_pkg;

    typedef enum logic [1:0] {HOLD, MIN, SEQ, RUN} rst_state_t;

    // Slice 0 (LSB) is the first stage: SDRAM/CPU 8, terminal 4, peripherals 2
    localparam logic [35:0] DEF_STAGE_DELAY = {12'd2, 12'd4, 12'd8};

    // Delay values of 0 behave as 1
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: two-flop synchroniser with selectable reset value
module sync_bit #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises reset requests and releases reset domains in order
module reset_sequencer
    import pdp11_reset_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int N_STAGES   = 3,
    parameter int CNT_W      = 12,
    parameter int MIN_ASSERT = 16,
    parameter logic [N_STAGES*CNT_W-1:0] STAGE_DELAY = DEF_STAGE_DELAY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_mask,
    output logic [N_STAGES-1:0] stage_rst,
    output logic                busy,
    output logic                done,
    output logic [7:0]          restart_count
);

    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(max1(MIN_ASSERT) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    logic [NREQ-1:0]  req_sync;
    logic             any_req;
    rst_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] stage_last [N_STAGES];

    for (genvar i = 0; i < NREQ; i++) begin : g_sync
        sync_bit #(.RST_VAL(1'b1)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (req[i]),
            .q     (req_sync[i])
        );
    end

    // Terminal count per stage; a zero delay behaves as one cycle
    for (genvar i = 0; i < N_STAGES; i++) begin : g_last
        assign stage_last[i] = (STAGE_DELAY[i*CNT_W +: CNT_W] == '0) ? '0
                             : STAGE_DELAY[i*CNT_W +: CNT_W] - 1'b1;
    end

    assign any_req = |(req_sync & ~req_mask);

    // Sequencer FSM: a live request always wins over any counter match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HOLD;
            cnt           <= '0;
            idx           <= '0;
            stage_rst     <= '1;
            busy          <= 1'b1;
            done          <= 1'b0;
            restart_count <= '0;
        end else begin
            done <= 1'b0;
            if (any_req) begin
                state     <= HOLD;
                cnt       <= '0;
                idx       <= '0;
                stage_rst <= '1;
                busy      <= 1'b1;
                if ((state == MIN || state == SEQ) && restart_count != 8'hFF)
                    restart_count <= restart_count + 8'd1;
            end else begin
                case (state)
                    HOLD: begin
                        state <= MIN;
                        cnt   <= '0;
                    end
                    MIN: begin
                        if (cnt == MIN_LAST) begin
                            state <= SEQ;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SEQ: begin
                        if (cnt == stage_last[idx]) begin
                            stage_rst[idx] <= 1'b0;
                            cnt            <= '0;
                            if (idx == LAST_IDX) begin
                                state <= RUN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: state <= RUN;
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule
